// File: rtl/logic_issue_stage.sv
// logic_issue_stage: request FIFO -> operand-isolated issue register -> response
// register wrapped around an external combinational 8-bit and/or/not unit.
// Optional build macro ALU_BYPASS_EN: requests arriving at an empty FIFO with a
// free issue slot load the issue register directly, cutting latency to one cycle.
module logic_issue_stage #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [W-1:0] lu_a,
    output logic [W-1:0] lu_b,
    output logic [1:0]   lu_ctrl,
    input  logic [W-1:0] lu_s,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic         busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } req_t;

    req_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;
    logic          accept, push, pop, xfer, bypass, load;
    logic          issue_v, issue_err;
    req_t          in_req, head, ld_req;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign req_ready = !fifo_full;
    assign accept    = req_valid && req_ready;
    assign in_req    = '{op: req_op, a: req_a, b: req_b};
    assign head      = mem[rd_ptr[AW-1:0]];

    assign xfer = issue_v && (!rsp_valid || rsp_ready);
    assign pop  = !fifo_empty && (!issue_v || xfer);

`ifdef ALU_BYPASS_EN
    // Bypass only when the FIFO is empty so ordering is preserved.
    assign bypass = accept && fifo_empty && (!issue_v || xfer);
`else
    assign bypass = 1'b0;
`endif

    // pop and bypass are exclusive: bypass requires an empty FIFO.
    assign push   = accept && !bypass;
    assign load   = pop || bypass;
    assign ld_req = pop ? head : in_req;

    assign busy = !fifo_empty || issue_v || rsp_valid;

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_req;
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Issue register: lu_* only move on a legal op so the ALU inputs stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_v   <= 1'b0;
            issue_err <= 1'b0;
            lu_a      <= '0;
            lu_b      <= '0;
            lu_ctrl   <= '0;
        end else if (load) begin
            issue_v   <= 1'b1;
            issue_err <= (ld_req.op == 2'b11);
            if (ld_req.op != 2'b11) begin
                lu_a    <= ld_req.a;
                lu_b    <= ld_req.b;
                lu_ctrl <= ld_req.op;
            end
        end else if (xfer) begin
            issue_v <= 1'b0;
        end
    end

    // Response register: captures the unit result, data/flags hold once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            if (issue_err) begin
                rsp_data <= '0;
                rsp_zero <= 1'b0;
                rsp_err  <= 1'b1;
            end else begin
                rsp_data <= lu_s;
                rsp_zero <= (lu_s == '0);
                rsp_err  <= 1'b0;
            end
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_issue_stage.sv
// tb_logic_issue_stage: table vectors, directed corner sequences and a random
// run scored against a queue-based reference of expected responses.
module tb_logic_issue_stage;
    localparam int W     = 8;
    localparam int DEPTH = 2;
`ifdef ALU_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
    logic [1:0]   req_op = '0, lu_ctrl;
    logic [W-1:0] req_a = '0, req_b = '0, lu_a, lu_b, lu_s, rsp_data;
    logic         rsp_zero, rsp_err, busy;

    logic_issue_stage #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .lu_a(lu_a), .lu_b(lu_b), .lu_ctrl(lu_ctrl), .lu_s(lu_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
    );

    // The logic unit itself.
    assign lu_s = (lu_ctrl == 2'b00) ? (lu_a & lu_b) :
                  (lu_ctrl == 2'b01) ? (lu_a | lu_b) :
                  (lu_ctrl == 2'b10) ? ~lu_a : '0;

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         zero;
        logic         err;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] data;
        logic         zero, err;
    } vec_t;

    exp_t exp_q[$];
    int   rsp_cyc[$];
    int   n_tests = 0, n_fail = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        case (op)
            2'b00:   e.data = a & b;
            2'b01:   e.data = a | b;
            2'b10:   e.data = ~a;
            default: e.data = '0;
        endcase
        e.err  = (op == 2'b11);
        e.zero = !e.err && (e.data == '0);
        return e;
    endfunction

    // Scoreboard: everything accepted and not yet delivered sits in exp_q.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, exp_q.size() != 0);
            chk("in_flight_bound", exp_q.size() <= DEPTH + 2, 1);
            if (rsp_valid && rsp_ready) begin
                chk("rsp_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_zero", rsp_zero, e.zero);
                    chk("rsp_err", rsp_err, e.err);
                    rsp_cyc.push_back(cyc);
                end
            end
            if (req_valid && req_ready) exp_q.push_back(model(req_op, req_a, req_b));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("send_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        while (busy && n < 200) begin @(negedge clk); n++; end
        chk("idle", busy, 0);
        chk("model_drained", exp_q.size(), 0);
        tick();
    endtask

    vec_t vecs[9];
    exp_t hold;

    initial begin
        vecs[0] = '{2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{2'b10, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{2'b01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{2'b10, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{2'b01, 8'h80, 8'h01, 8'h81, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_lu", {lu_a, lu_b, lu_ctrl}, 0);
        chk("rst_rsp", {rsp_data, rsp_zero, rsp_err}, 0);
        rst_n = 1'b1;
        tick();

        // Single op latency
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 2'b00; req_a = 8'hF0; req_b = 8'h3C;
        tick();
        req_valid = 1'b0;
        repeat (LAT - 1) begin chk("lat_early_rsp", rsp_valid, 0); tick(); end
        chk("lat_lu_a", lu_a, 8'hF0);
        chk("lat_lu_ctrl", lu_ctrl, 2'b00);
        chk("lat_pre_rsp", rsp_valid, 0);
        tick();
        chk("lat_rsp_valid", rsp_valid, 1);
        chk("lat_rsp_data", rsp_data, 8'h30);
        chk("lat_rsp_flags", {rsp_zero, rsp_err}, 2'b00);
        wait_idle();

        // Table-driven single ops
        for (int i = 0; i < 9; i++) begin
            int n = 0;
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
            while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
            chk("vec_rsp_valid", rsp_valid, 1);
            chk("vec_data", rsp_data, vecs[i].data);
            chk("vec_zero", rsp_zero, vecs[i].zero);
            chk("vec_err", rsp_err, vecs[i].err);
            tick();
        end
        wait_idle();

        // Back-to-back stream: three responses on consecutive cycles
        rsp_cyc.delete();
        send(2'b01, 8'h0F, 8'hF0);
        send(2'b10, 8'hFF, 8'h00);
        send(2'b00, 8'hAA, 8'h55);
        wait_idle();
        chk("b2b_count", rsp_cyc.size(), 3);
        if (rsp_cyc.size() == 3) chk("b2b_spacing", rsp_cyc[2] - rsp_cyc[0], 2);

        // Backpressure: DEPTH+2 accepted, then stall, then drain in order
        begin
            int acc = 0;
            rsp_ready = 1'b0;
            for (int c = 0; c < 8; c++) begin
                req_valid = 1'b1; req_op = 2'(acc); req_a = 8'(8'h11 * (acc + 1)); req_b = 8'h0F;
                @(negedge clk);
                if (req_ready) acc++;
                tick();
            end
            chk("bp_accepted", acc, DEPTH + 2);
            chk("bp_stalled", req_ready, 0);
            rsp_ready = 1'b1;
            for (int c = 0; c < 20 && acc < 5; c++) begin
                @(negedge clk);
                if (req_ready) acc++;
                tick();
            end
            req_valid = 1'b0;
            chk("bp_fifth", acc, 5);
            wait_idle();
        end

        // Illegal op keeps lu_* isolated
        send(2'b00, 8'h77, 8'h00);
        wait_idle();
        chk("ill_pre_lu_a", lu_a, 8'h77);
        send(2'b11, 8'h12, 8'h34);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("ill_lu_a", lu_a, 8'h77);
            chk("ill_lu_ctrl", lu_ctrl, 2'b00);
            if (rsp_valid) chk("ill_err", {rsp_err, rsp_data}, {1'b1, 8'h00});
        end
        tick();
        wait_idle();

        // Reset mid-flight
        rsp_ready = 1'b0;
        send(2'b00, 8'h0F, 8'hFF);
        send(2'b01, 8'h10, 8'h01);
        send(2'b10, 8'h33, 8'h00);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mrst_outputs", {lu_a, lu_b, lu_ctrl, rsp_data, rsp_zero, rsp_err, rsp_valid}, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_req_ready", req_ready, 1);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mrst_no_stale", rsp_valid, 0);
        end
        tick();

`ifdef ALU_BYPASS_EN
        // Bypass: one-cycle latency into an empty pipeline
        req_valid = 1'b1; req_op = 2'b01; req_a = 8'h01; req_b = 8'h02;
        tick();
        req_valid = 1'b0;
        chk("byp_early", rsp_valid, 0);
        tick();
        chk("byp_rsp", {rsp_valid, rsp_data}, {1'b1, 8'h03});
        wait_idle();
`endif

        // Random traffic against the reference queue
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_op    = 2'($urandom_range(0, 3));
            req_a     = 8'($urandom);
            req_b     = 8'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        req_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want $finish before timeout");
        $fatal(1);
    end

endmodule
